mcdf_arbiter: RTL and testbench

- Sits directly downstream of the three slave_fifo channels and upstream of the formatter.
- Picks one requesting channel per packet: lowest priority value wins, ties broken round-robin.
- Acks the chosen channel and forwards its packet words to the formatter, registered, tagged with channel id and start/end-of-packet markers.

---
 rtl/mcdf_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_mcdf_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcdf_arbiter.sv
// mcdf_arbiter: picks one of three slave channels per packet (lowest prio, round-robin ties)
// and forwards its words to the formatter. Optional wait timeout: define ARB_TIMEOUT_EN.
module mcdf_arbiter #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          slv0_req_i,
  input  logic          slv1_req_i,
  input  logic          slv2_req_i,
  input  logic          slv0_valid_i,
  input  logic          slv1_valid_i,
  input  logic          slv2_valid_i,
  input  logic [DW-1:0] slv0_data_i,
  input  logic [DW-1:0] slv1_data_i,
  input  logic [DW-1:0] slv2_data_i,
  input  logic          slv0_en_i,
  input  logic          slv1_en_i,
  input  logic          slv2_en_i,
  input  logic [1:0]    slv0_prio_i,
  input  logic [1:0]    slv1_prio_i,
  input  logic [1:0]    slv2_prio_i,
  input  logic [2:0]    slv0_pkglen_i,
  input  logic [2:0]    slv1_pkglen_i,
  input  logic [2:0]    slv2_pkglen_i,
  output logic          a2s0_ack_o,
  output logic          a2s1_ack_o,
  output logic          a2s2_ack_o,
  input  logic          f2a_ready_i,
  output logic          a2f_valid_o,
  output logic [DW-1:0] a2f_data_o,
  output logic [1:0]    a2f_id_o,
  output logic          a2f_sop_o,
  output logic          a2f_eop_o,
  output logic [5:0]    a2f_len_o,
  output logic          arb_busy_o,
  output logic          arb_err_o
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  // Channel inputs gathered into arrays indexed by channel id.
  logic [2:0]          req, en, valid;
  logic [2:0][1:0]     prio;
  logic [2:0][2:0]     pkglen;
  logic [2:0][DW-1:0]  data;

  assign req    = {slv2_req_i, slv1_req_i, slv0_req_i};
  assign en     = {slv2_en_i, slv1_en_i, slv0_en_i};
  assign valid  = {slv2_valid_i, slv1_valid_i, slv0_valid_i};
  assign prio   = {slv2_prio_i, slv1_prio_i, slv0_prio_i};
  assign pkglen = {slv2_pkglen_i, slv1_pkglen_i, slv0_pkglen_i};
  assign data   = {slv2_data_i, slv1_data_i, slv0_data_i};

  // Registered state and outputs (_q) with their next values (_d).
  state_t          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [5:0]      len_q, len_d;
  logic [1:0]      rr_q, rr_d;
  logic [2:0]      ack_q, ack_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   data_q, data_d;
  logic [1:0]      id_q, id_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;
  logic            busy_q, busy_d;

`ifdef ARB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
`endif

  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

  // Packet-length code to (length - 1).
  function automatic logic [5:0] decode_len_m1(input logic [2:0] code);
    case (code)
      3'd0:    return 6'd3;
      3'd1:    return 6'd7;
      3'd2:    return 6'd15;
      default: return 6'd31;
    endcase
  endfunction

  // Arbitration: find the best priority, then scan channels starting after rr_q.
  logic [2:0] elig;
  logic [1:0] min_prio;
  logic [1:0] cand;
  logic       win_found;
  logic [1:0] win_id;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    elig      = req & en;
    min_prio  = 2'd3;
    win_found = 1'b0;
    win_id    = 2'd0;
    cand      = rr_q;
    if (elig[0] && prio[0] < min_prio) min_prio = prio[0];
    if (elig[1] && prio[1] < min_prio) min_prio = prio[1];
    if (elig[2] && prio[2] < min_prio) min_prio = prio[2];
    for (int k = 0; k < 3; k++) begin
      cand = next_ch(cand);
      if (!win_found && elig[cand] && prio[cand] == min_prio) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  logic          sel_valid;
  logic [DW-1:0] sel_data;

  assign sel_valid = valid[sel_q];
  assign sel_data  = data[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    rr_d    = rr_q;
    ack_d   = 3'b000;
    valid_d = 1'b0;
    data_d  = data_q;
    id_d    = id_q;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    busy_d  = busy_q;
`ifdef ARB_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found && f2a_ready_i) begin
          state_d       = XFER;
          sel_d         = win_id;
          len_d         = decode_len_m1(pkglen[win_id]);
          rr_d          = win_id;
          ack_d[win_id] = 1'b1;
          busy_d        = 1'b1;
          cnt_d         = 6'd0;
`ifdef ARB_TIMEOUT_EN
          wait_d        = '0;
`endif
        end
      end
      XFER: begin
        // The formatter reserved room for the whole packet, so words are never stalled.
        if (sel_valid) begin
          valid_d = 1'b1;
          data_d  = sel_data;
          id_d    = sel_q;
          sop_d   = (cnt_q == 6'd0);
          eop_d   = (cnt_q == len_q);
          if (cnt_q == len_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == 6'd0) begin
          if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= 6'd0;
      len_q   <= 6'd0;
      rr_q    <= 2'd2;
      ack_q   <= 3'b000;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= 2'd0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      rr_q    <= rr_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      busy_q  <= busy_d;
`ifdef ARB_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  assign a2s0_ack_o  = ack_q[0];
  assign a2s1_ack_o  = ack_q[1];
  assign a2s2_ack_o  = ack_q[2];
  assign a2f_valid_o = valid_q;
  assign a2f_data_o  = data_q;
  assign a2f_id_o    = id_q;
  assign a2f_sop_o   = sop_q;
  assign a2f_eop_o   = eop_q;
  assign a2f_len_o   = len_q;
  assign arb_busy_o  = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign arb_err_o   = err_q;
`else
  assign arb_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Self-checking bench for mcdf_arbiter: first-grant vector table, directed packet
// sequences and a randomized run against a transaction-level reference model.
module tb_mcdf_arbiter;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]    req, en, valid;
  logic [1:0]    prio   [3];
  logic [2:0]    pkglen [3];
  logic [DW-1:0] data   [3];
  logic          ready;

  logic          ack0, ack1, ack2;
  logic [2:0]    ack_v;
  logic          a2f_valid, a2f_sop, a2f_eop, busy, err;
  logic [DW-1:0] a2f_data;
  logic [1:0]    a2f_id;
  logic [5:0]    a2f_len;

  assign ack_v = {ack2, ack1, ack0};

  mcdf_arbiter #(.DW(DW), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .slv0_req_i(req[0]), .slv1_req_i(req[1]), .slv2_req_i(req[2]),
    .slv0_valid_i(valid[0]), .slv1_valid_i(valid[1]), .slv2_valid_i(valid[2]),
    .slv0_data_i(data[0]), .slv1_data_i(data[1]), .slv2_data_i(data[2]),
    .slv0_en_i(en[0]), .slv1_en_i(en[1]), .slv2_en_i(en[2]),
    .slv0_prio_i(prio[0]), .slv1_prio_i(prio[1]), .slv2_prio_i(prio[2]),
    .slv0_pkglen_i(pkglen[0]), .slv1_pkglen_i(pkglen[1]), .slv2_pkglen_i(pkglen[2]),
    .a2s0_ack_o(ack0), .a2s1_ack_o(ack1), .a2s2_ack_o(ack2),
    .f2a_ready_i(ready),
    .a2f_valid_o(a2f_valid), .a2f_data_o(a2f_data), .a2f_id_o(a2f_id),
    .a2f_sop_o(a2f_sop), .a2f_eop_o(a2f_eop), .a2f_len_o(a2f_len),
    .arb_busy_o(busy), .arb_err_o(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit            m_busy;
  int            m_sel, m_len, m_cnt, m_rr;
  logic [2:0]    e_ack;
  logic          e_valid, e_sop, e_eop, e_busy;
  logic [DW-1:0] e_data;
  logic [1:0]    e_id;
  logic [5:0]    e_len;

  function automatic int decode(input logic [2:0] code);
    return (code == 0) ? 4 : (code == 1) ? 8 : (code == 2) ? 16 : 32;
  endfunction

  // Evaluates what the next clock edge does with the inputs currently applied.
  task automatic model_step();
    int best, best_score, s;
    e_ack = 3'b000; e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0;
    if (rst) begin
      m_busy = 0; m_cnt = 0; m_rr = 2;
      e_data = '0; e_id = 2'd0; e_len = 6'd0; e_busy = 1'b0;
      return;
    end
    if (!m_busy) begin
      if (ready) begin
        best = -1; best_score = 1000;
        for (int i = 0; i < 3; i++) begin
          if (req[i] && en[i]) begin
            // priority dominates; distance after last winner breaks ties
            s = int'(prio[i]) * 3 + ((i - m_rr + 5) % 3);
            if (s < best_score) begin best_score = s; best = i; end
          end
        end
        if (best >= 0) begin
          m_sel = best; m_len = decode(pkglen[best]); m_rr = best;
          m_busy = 1; m_cnt = 0;
          e_ack[best] = 1'b1;
          e_len = 6'(m_len - 1);
        end
      end
    end else if (valid[m_sel]) begin
      e_valid = 1'b1;
      e_data  = data[m_sel];
      e_id    = 2'(m_sel);
      e_sop   = (m_cnt == 0);
      e_eop   = (m_cnt == m_len - 1);
      m_cnt++;
      if (e_eop) begin m_busy = 0; m_cnt = 0; end
    end
    e_busy = m_busy;
  endtask

  // ---------------- slave streamer and observation ----------------
  bit            stream_en, gap_mode, phase, auto_drop;
  int            act_ch = -1, sent, total;
  logic [DW-1:0] base, step;
  logic [2:0]    spur;
  int            grants[$];
  int            n_words, cyc, last_eop_cyc, min_gap, bad_id, watch_id, eop_words;
  bit            eop_seen;
  logic [DW-1:0] sop_data, eop_data;

  task automatic clear_obs();
    grants.delete();
    n_words = 0; last_eop_cyc = -1; min_gap = 1000; bad_id = 0;
    eop_seen = 0; eop_words = 0; sop_data = '0; eop_data = '0;
  endtask

  task automatic clear_stream();
    act_ch = -1; sent = 0; phase = 0;
    valid = 3'b000;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("ack", ack_v, e_ack);
    check("a2f_valid", a2f_valid, e_valid);
    check("a2f_sop", a2f_sop, e_sop);
    check("a2f_eop", a2f_eop, e_eop);
    check("arb_busy", busy, e_busy);
    check("a2f_len", a2f_len, e_len);
    check("arb_err", err, 1'b0);
    if (e_valid) begin
      check("a2f_data", a2f_data, e_data);
      check("a2f_id", a2f_id, e_id);
    end
    // observation for the directed-sequence checks
    if (ack_v != 3'b000) grants.push_back(ack_v[1] ? 1 : (ack_v[2] ? 2 : 0));
    if (a2f_valid) begin
      n_words++;
      if (int'(a2f_id) != watch_id) bad_id++;
      if (a2f_sop) begin
        sop_data = a2f_data;
        if (last_eop_cyc >= 0 && cyc - last_eop_cyc - 1 < min_gap) min_gap = cyc - last_eop_cyc - 1;
      end
      if (a2f_eop) begin
        eop_seen = 1; eop_data = a2f_data; eop_words = n_words; last_eop_cyc = cyc;
      end
    end
    cyc++;
    if (stream_en) begin
      valid = spur;
      for (int i = 0; i < 3; i++) if (spur[i]) data[i] = 32'hDEAD_0000 + i;
      if (e_ack != 3'b000) begin
        act_ch = e_ack[1] ? 1 : (e_ack[2] ? 2 : 0);
        sent = 0; total = decode(pkglen[act_ch]); phase = 0;
      end
      if (act_ch >= 0) begin
        if (gap_mode && phase) begin
          valid[act_ch] = 1'b0;
        end else begin
          valid[act_ch] = 1'b1;
          data[act_ch]  = base + step * DW'(sent) + (DW'(act_ch) << 16);
          sent++;
          if (sent == total) begin
            if (auto_drop) req[act_ch] = 1'b0;
            act_ch = -1;
          end
        end
        phase = ~phase;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_stream();
    clear_obs();
  endtask

  task automatic set_ch(input int ch, input logic [1:0] p, input logic [2:0] l);
    prio[ch] = p; pkglen[ch] = l;
  endtask

  // ---------------- first-grant vector table ----------------
  typedef struct {
    logic [2:0] req, en;
    logic [1:0] p0, p1, p2;
    logic [2:0] l0, l1, l2;
    logic [2:0] exp_ack;
    logic [5:0] exp_len;
  } vec_t;

  vec_t tbl[9];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; en = '0; valid = '0; ready = 1'b0;
    spur = '0; stream_en = 0; gap_mode = 0; auto_drop = 0; watch_id = -1;
    base = '0; step = '0; cyc = 0;
    for (int i = 0; i < 3; i++) begin prio[i] = '0; pkglen[i] = '0; data[i] = '0; end
    clear_obs();

    // After reset (rr_last = 2, so ch0 is first among ties).
    tbl[0] = '{3'b001, 3'b111, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 3'b001, 6'd3};
    tbl[1] = '{3'b111, 3'b111, 2'd2, 2'd1, 2'd3, 3'd3, 3'd3, 3'd3, 3'b010, 6'd31};
    tbl[2] = '{3'b110, 3'b011, 2'd0, 2'd0, 2'd0, 3'd0, 3'd1, 3'd2, 3'b010, 6'd7};
    tbl[3] = '{3'b111, 3'b111, 2'd0, 2'd0, 2'd0, 3'd2, 3'd0, 3'd0, 3'b001, 6'd15};
    tbl[4] = '{3'b110, 3'b111, 2'd3, 2'd3, 2'd3, 3'd0, 3'd6, 3'd0, 3'b010, 6'd31};
    tbl[5] = '{3'b101, 3'b111, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0, 3'd1, 3'b100, 6'd7};
    tbl[6] = '{3'b111, 3'b000, 2'd0, 2'd0, 2'd0, 3'd1, 3'd1, 3'd1, 3'b000, 6'd0};
    tbl[7] = '{3'b100, 3'b100, 2'd0, 2'd0, 2'd2, 3'd0, 3'd0, 3'd7, 3'b100, 6'd31};
    tbl[8] = '{3'b011, 3'b111, 2'd1, 2'd1, 2'd0, 3'd1, 3'd2, 3'd0, 3'b001, 6'd7};

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_ack", ack_v, 3'b000);
    check("reset_valid", a2f_valid, 1'b0);
    check("reset_data", a2f_data, '0);
    check("reset_id", a2f_id, 2'd0);
    check("reset_sop_eop", {a2f_sop, a2f_eop}, 2'b00);
    check("reset_len", a2f_len, 6'd0);
    check("reset_busy_err", {busy, err}, 2'b00);

    for (int v = 0; v < 9; v++) begin
      rst = 1'b1; ready = 1'b0; req = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      req = tbl[v].req; en = tbl[v].en; ready = 1'b1;
      prio[0] = tbl[v].p0; prio[1] = tbl[v].p1; prio[2] = tbl[v].p2;
      pkglen[0] = tbl[v].l0; pkglen[1] = tbl[v].l1; pkglen[2] = tbl[v].l2;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_ack", v), ack_v, tbl[v].exp_ack);
      check($sformatf("tbl%0d_busy", v), busy, tbl[v].exp_ack != 3'b000);
      check($sformatf("tbl%0d_len", v), a2f_len, tbl[v].exp_len);
      check($sformatf("tbl%0d_valid", v), a2f_valid, 1'b0);
    end
    req = '0; ready = 1'b0;

    // ---- A: full packet, then reset in the middle of the next one ----
    stream_en = 1;
    do_reset();
    en = 3'b001; set_ch(0, 2'd0, 3'd0); req = 3'b001; ready = 1'b1;
    base = 10; step = 10; watch_id = 0;
    for (int k = 0; k < 20 && !eop_seen; k++) tick();
    check("A_eop_seen", eop_seen, 1'b1);
    check("A_ack_count", grants.size(), 1);
    check("A_sop_data", sop_data, 32'd10);
    check("A_eop_data", eop_data, 32'd40);
    check("A_words", eop_words, 4);
    check("A_bad_id", bad_id, 0);
    for (int k = 0; k < 20 && n_words < 6; k++) tick();
    check("A_second_pkt_words", n_words, 6);
    rst = 1'b1;
    tick();
    check("A_rst_ack", ack_v, 3'b000);
    check("A_rst_outputs", {a2f_valid, a2f_sop, a2f_eop, busy, err}, 5'b0);
    check("A_rst_data_len", {a2f_data, a2f_len}, '0);
    rst = 1'b0; clear_stream(); req = '0;
    tick();
    tick();

    // ---- B: fixed priority, 32-word packets ----
    do_reset();
    en = 3'b111; set_ch(0, 2'd2, 3'd3); set_ch(1, 2'd1, 3'd3); set_ch(2, 2'd3, 3'd3);
    req = 3'b111; ready = 1'b1; auto_drop = 1; base = 32'h100; step = 1; watch_id = -1;
    for (int k = 0; k < 120; k++) tick();
    check("B_grants", grants.size(), 3);
    if (grants.size() == 3) check("B_order", {grants[0], grants[1], grants[2]}, {32'd1, 32'd0, 32'd2});
    check("B_words", n_words, 96);
    auto_drop = 0;

    // ---- C: round-robin among equal priorities ----
    do_reset();
    en = 3'b111; set_ch(0, 2'd0, 3'd1); set_ch(1, 2'd0, 3'd1); set_ch(2, 2'd0, 3'd1);
    req = 3'b111; ready = 1'b1; base = 32'h200; step = 1;
    for (int k = 0; k < 60; k++) tick();
    req = 3'b000;
    for (int k = 0; k < 12; k++) tick();
    check("C_grants_ge6", grants.size() >= 6, 1'b1);
    if (grants.size() >= 6)
      check("C_order", {grants[0], grants[1], grants[2], grants[3], grants[4], grants[5]},
            {32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2});
    check("C_words", n_words, 8 * grants.size());
    check("C_min_gap", min_gap, 1);

    // ---- D: formatter not ready holds off the grant ----
    do_reset();
    en = 3'b100; set_ch(2, 2'd0, 3'd0); req = 3'b100; ready = 1'b0; base = 32'h300;
    for (int k = 0; k < 5; k++) tick();
    check("D_no_ack", grants.size(), 0);
    ready = 1'b1;
    tick();
    check("D_ack_ch2", ack_v, 3'b100);
    ready = 1'b0;
    for (int k = 0; k < 10 && !eop_seen; k++) tick();
    check("D_complete", eop_words, 4);
    req = '0;
    tick();

    // ---- E: valid gaps on ch1 with spurious ch0 valid ----
    do_reset();
    en = 3'b011; set_ch(1, 2'd0, 3'd1); req = 3'b010; ready = 1'b1;
    gap_mode = 1; spur = 3'b001; base = 32'h400; watch_id = 1;
    for (int k = 0; k < 30 && !eop_seen; k++) tick();
    check("E_eop_word", eop_words, 8);
    check("E_only_ch1", bad_id, 0);
    req = '0; gap_mode = 0; spur = '0;
    tick(); tick();

    // ---- randomized run against the model ----
    stream_en = 0;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      tick();
      rst   = ($urandom_range(0, 299) == 0);
      req   = 3'($urandom);
      ready = $urandom_range(0, 1) == 1;
      for (int i = 0; i < 3; i++) begin
        en[i]    = ($urandom_range(0, 7) != 0);
        valid[i] = ($urandom_range(0, 3) != 0);
        data[i]  = $urandom;
        if ($urandom_range(0, 7) == 0) prio[i]   = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) pkglen[i] = 3'($urandom_range(0, 7));
      end
    end
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
